// File: rtl/data_bus_memory.sv
// rtl/data_bus_memory.sv - data-bus responder RAM with wait states, busy stall and fault pulse
module data_bus_memory #(
    parameter int          DEPTH_LOG2     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int          WAIT_STATES    = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [DEPTH_LOG2-1:0] SWEEP_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_DONE} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_wait;
    logic [DEPTH_LOG2-1:0] r_sweep;
    logic                  r_rd;
    logic                  r_wd;
    logic [1:0]            r_size;
    logic [31:0]           r_addr;
    logic [31:0]           r_data;
    logic [31:0]           r_data_out;
    logic                  r_fault;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_execute;
    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic                  w_fault;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [31:0]           w_word;
    logic [31:0]           w_shifted;
    logic [31:0]           w_rdata;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic                  w_sweep_we;
    logic                  w_mem_we;

    // Address decode and request validation on the latched request
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_in_range = (w_offset >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign w_index    = w_offset[DEPTH_LOG2+1:2];
    assign w_fault    = (r_rd & r_wd)
                      | (r_size == 2'b11)
                      | ((r_size == 2'b01) & r_addr[0])
                      | ((r_size == 2'b10) & (r_addr[1:0] != 2'b00))
                      | ~w_in_range;

    // Half accesses are aligned, so one lane shifter serves byte and half reads
    assign w_word    = r_mem[w_index];
    assign w_shifted = w_word >> {r_addr[1:0], 3'b000};

    // Read extraction and write lane steering
    always_comb begin
        w_rdata = 32'd0;
        w_be    = 4'b0000;
        w_wdata = r_data;
        case (r_size)
            2'b00: begin
                w_rdata = {24'd0, w_shifted[7:0]};
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_data[7:0]}};
            end
            2'b01: begin
                w_rdata = {16'd0, w_shifted[15:0]};
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_data[15:0]}};
            end
            2'b10: begin
                w_rdata = w_word;
                w_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Next-state logic; ACCESS runs at least one cycle, so WAIT_STATES 0 and 1 coincide
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_execute    = 1'b0;
        case (r_state)
            S_INIT:   if (r_sweep == '1) w_next_state = S_IDLE;
            S_IDLE:   if (rd | wd) begin
                          w_accept     = 1'b1;
                          w_next_state = S_ACCESS;
                      end
            S_ACCESS: if (r_wait <= 4'd1) begin
                          w_execute    = 1'b1;
                          w_next_state = S_DONE;
                      end
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = RESET_STATE;
        endcase
    end

    assign busy       = ~rst & (((r_state == S_IDLE) & (rd | wd)) | (r_state == S_ACCESS));
    assign ready      = ~rst & (r_state != S_INIT);
    assign fault      = r_fault;
    assign data_out   = r_data_out;
    assign w_sweep_we = ~rst & (r_state == S_INIT);
    assign w_mem_we   = ~rst & w_execute & r_wd & ~w_fault;

    // State, request latch, wait counter, sweep pointer and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RESET_STATE;
            r_wait     <= 4'd0;
            r_sweep    <= '0;
            r_rd       <= 1'b0;
            r_wd       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_data_out <= 32'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_execute & w_fault;
            if (r_state == S_INIT) r_sweep <= r_sweep + SWEEP_ONE;
            if (w_accept) begin
                r_rd   <= rd;
                r_wd   <= wd;
                r_size <= size;
                r_addr <= addr;
                r_data <= data_in;
                r_wait <= WAIT_INIT;
            end else if ((r_state == S_ACCESS) && !w_execute) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_execute && r_rd) r_data_out <= w_fault ? 32'd0 : w_rdata;
        end
    end

    // Storage array: zero sweep during INIT, byte-lane writes on execute
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_sweep] <= 32'd0;
        end else if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_bus_memory.sv
// tb/tb_data_bus_memory.sv - directed table-driven bench for data_bus_memory
module tb_data_bus_memory;

    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic        r;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic        f;
        logic [31:0] q;
    } vec_t;

    logic        clk;
    logic        rst_s   [2];
    logic        wd_s    [2];
    logic        rd_s    [2];
    logic [1:0]  size_s  [2];
    logic [31:0] addr_s  [2];
    logic [31:0] din_s   [2];
    logic [31:0] dout_s  [2];
    logic        ready_s [2];
    logic        busy_s  [2];
    logic        fault_s [2];

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs [24];

    data_bus_memory #(.DEPTH_LOG2(4), .BASE_ADDR(BASE), .WAIT_STATES(1), .CLEAR_ON_RESET(1'b1)) u0 (
        .clk(clk), .rst(rst_s[0]), .wd(wd_s[0]), .rd(rd_s[0]), .size(size_s[0]),
        .addr(addr_s[0]), .data_in(din_s[0]), .data_out(dout_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .fault(fault_s[0]));

    data_bus_memory #(.DEPTH_LOG2(4), .BASE_ADDR(BASE), .WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)) u1 (
        .clk(clk), .rst(rst_s[1]), .wd(wd_s[1]), .rd(rd_s[1]), .size(size_s[1]),
        .addr(addr_s[1]), .data_in(din_s[1]), .data_out(dout_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .fault(fault_s[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge and hold it until DONE; optionally disturb inputs after acceptance
    task automatic run_req(input int d, input logic r, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] dat, input bit mutate,
                           output logic [31:0] q, output logic f, output int lat);
        rd_s[d] = r; wd_s[d] = w; size_s[d] = sz; addr_s[d] = a; din_s[d] = dat;
        #1;
        chk("busy_in_idle", 32'(busy_s[d]), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mutate && lat == 1) begin
                addr_s[d] = a ^ 32'h4;
                size_s[d] = 2'b11;
                din_s[d]  = ~dat;
            end
            if (busy_s[d]) chk("fault_low_in_access", 32'(fault_s[d]), 32'd0);
        end while (busy_s[d] && lat < 40);
        q = dout_s[d];
        f = fault_s[d];
        rd_s[d] = 1'b0;
        wd_s[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("fault_one_cycle", 32'(fault_s[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic        f;
        int          lat;
        int          n;

        vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h1000, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 32'h1002, 32'hFFFFFF55, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 32'h1000, 32'h0,        1'b0, 32'hDE55BEEF};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 32'h1002, 32'h0,        1'b0, 32'h0000DE55};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h1003, 32'h0,        1'b0, 32'h000000DE};
        vecs[6]  = '{1'b0, 1'b1, 2'b01, 32'h1001, 32'h00001111, 1'b1, 32'h000000DE};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 32'h1002, 32'h0,        1'b1, 32'h00000000};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 32'h0FFC, 32'h0,        1'b1, 32'h00000000};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h1000, 32'h0,        1'b0, 32'hDE55BEEF};
        vecs[10] = '{1'b1, 1'b1, 2'b10, 32'h1004, 32'hCAFEF00D, 1'b1, 32'h00000000};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h1004, 32'h0,        1'b0, 32'h00000000};
        vecs[12] = '{1'b1, 1'b0, 2'b11, 32'h1000, 32'h0,        1'b1, 32'h00000000};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 32'h1006, 32'hABCD1234, 1'b0, 32'h00000000};
        vecs[14] = '{1'b0, 1'b1, 2'b00, 32'h1005, 32'h00000077, 1'b0, 32'h00000000};
        vecs[15] = '{1'b1, 1'b0, 2'b10, 32'h1004, 32'h0,        1'b0, 32'h12347700};
        vecs[16] = '{1'b1, 1'b0, 2'b01, 32'h1004, 32'h0,        1'b0, 32'h00007700};
        vecs[17] = '{1'b1, 1'b0, 2'b00, 32'h1007, 32'h0,        1'b0, 32'h00000012};
        vecs[18] = '{1'b1, 1'b0, 2'b10, 32'h1040, 32'h0,        1'b1, 32'h00000000};
        vecs[19] = '{1'b1, 1'b0, 2'b10, 32'h103C, 32'h0,        1'b0, 32'h00000000};
        vecs[20] = '{1'b0, 1'b1, 2'b10, 32'h103C, 32'h89ABCDEF, 1'b0, 32'h00000000};
        vecs[21] = '{1'b1, 1'b0, 2'b00, 32'h103E, 32'h0,        1'b0, 32'h000000AB};
        vecs[22] = '{1'b0, 1'b1, 2'b00, 32'h1040, 32'h000000EE, 1'b1, 32'h000000AB};
        vecs[23] = '{1'b1, 1'b0, 2'b01, 32'h1000, 32'h0,        1'b0, 32'h0000BEEF};

        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; wd_s[d] = 1'b0; rd_s[d] = 1'b0;
            size_s[d] = 2'b00; addr_s[d] = 32'd0; din_s[d] = 32'd0;
        end

        // Reset state, including busy forced low under a pending request
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_s[0] = 1'b1;
        #1;
        chk("rst_ready", 32'(ready_s[0]), 32'd0);
        chk("rst_busy", 32'(busy_s[0]), 32'd0);
        chk("rst_fault", 32'(fault_s[0]), 32'd0);
        chk("rst_dout", dout_s[0], 32'd0);
        chk("rst_ready_u1", 32'(ready_s[1]), 32'd0);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // Zero sweep: 16 cycles of ready low, requests ignored meanwhile
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("init_ready_low", 32'(ready_s[0]), 32'd0);
        chk("init_busy_low", 32'(busy_s[0]), 32'd0);
        chk("noclear_ready", 32'(ready_s[1]), 32'd1);
        rd_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("init_ready_high", 32'(ready_s[0]), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_req(0, 1'b1, 1'b0, 2'b10, BASE + 32'(4 * i), 32'd0, 1'b0, q, f, lat);
            chk($sformatf("sweep_word%0d", i), q, 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            run_req(0, vecs[i].r, vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d, 1'b0, q, f, lat);
            chk($sformatf("vec%0d_fault", i), 32'(f), 32'(vecs[i].f));
            chk($sformatf("vec%0d_dout", i), q, vecs[i].q);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Inputs disturbed after acceptance must not matter
        run_req(0, 1'b1, 1'b0, 2'b10, 32'h1000, 32'd0, 1'b1, q, f, lat);
        chk("mutate_read_dout", q, 32'hDE55BEEF);
        chk("mutate_read_fault", 32'(f), 32'd0);
        run_req(0, 1'b0, 1'b1, 2'b10, 32'h1008, 32'h11223344, 1'b1, q, f, lat);
        chk("mutate_write_fault", 32'(f), 32'd0);
        run_req(0, 1'b1, 1'b0, 2'b10, 32'h1008, 32'd0, 1'b0, q, f, lat);
        chk("mutate_write_data", q, 32'h11223344);
        run_req(0, 1'b1, 1'b0, 2'b10, 32'h100C, 32'd0, 1'b0, q, f, lat);
        chk("mutate_write_other", q, 32'd0);
        run_req(0, 1'b1, 1'b0, 2'b10, 32'h1000, 32'd0, 1'b0, q, f, lat);

        // Reset during ACCESS with zero sweep: write aborted and memory cleared
        wd_s[0] = 1'b1; size_s[0] = 2'b10; addr_s[0] = 32'h1004; din_s[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        rst_s[0] = 1'b1;
        #1;
        chk("abort0_busy", 32'(busy_s[0]), 32'd0);
        chk("abort0_ready", 32'(ready_s[0]), 32'd0);
        chk("abort0_dout", dout_s[0], 32'd0);
        chk("abort0_fault", 32'(fault_s[0]), 32'd0);
        wd_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_s[0] = 1'b0;
        n = 0;
        while (!ready_s[0] && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("abort0_reinit_cycles", 32'(n), 32'd16);
        run_req(0, 1'b1, 1'b0, 2'b10, 32'h1004, 32'd0, 1'b0, q, f, lat);
        chk("abort0_read_1004", q, 32'd0);
        run_req(0, 1'b1, 1'b0, 2'b10, 32'h1000, 32'd0, 1'b0, q, f, lat);
        chk("abort0_read_1000", q, 32'd0);

        // No zero sweep, three wait states: aborted write leaves prior contents
        run_req(1, 1'b0, 1'b1, 2'b10, 32'h1004, 32'hA5A5A5A5, 1'b0, q, f, lat);
        chk("u1_write_latency", 32'(lat), 32'd4);
        chk("u1_write_fault", 32'(f), 32'd0);
        run_req(1, 1'b1, 1'b0, 2'b10, 32'h1004, 32'd0, 1'b0, q, f, lat);
        chk("u1_read_latency", 32'(lat), 32'd4);
        chk("u1_read_data", q, 32'hA5A5A5A5);
        wd_s[1] = 1'b1; size_s[1] = 2'b10; addr_s[1] = 32'h1004; din_s[1] = 32'h12345678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_s[1] = 1'b1;
        #1;
        chk("abort1_busy", 32'(busy_s[1]), 32'd0);
        chk("abort1_ready", 32'(ready_s[1]), 32'd0);
        chk("abort1_dout", dout_s[1], 32'd0);
        wd_s[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_s[1] = 1'b0;
        #1;
        chk("abort1_ready_after", 32'(ready_s[1]), 32'd1);
        @(negedge clk);
        run_req(1, 1'b1, 1'b0, 2'b10, 32'h1004, 32'd0, 1'b0, q, f, lat);
        chk("abort1_read_prior", q, 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
